udiv_rr_arbiter: RTL and testbench
==================================

# udiv_rr_arbiter

- Round-robin arbiter that shares one unsigned divider (`udiv`) among `NUM_REQ` requesters.
- Typical requesters are per-channel sample CE generators that convert `sample_period_ns` to a terminal count.
- It sits between the requesters and the divider's input and output ports.
- It tags every issued operation with its requester index and routes each quotient/remainder back to the originator.
- The divider returns results in issue order.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DWIDTH`, 32: dividend, divisor and result width.
- `TAG_DEPTH`, 8: maximum operations in flight inside the divider; power of two, ≥ 2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high.
- `req_dividend`  in  NUM_REQ*DWIDTH  packed; requester i occupies bits [i*DWIDTH +: DWIDTH].
- `req_divisor`  in  NUM_REQ*DWIDTH  packed, same layout.
- `rsp_valid`  out  NUM_REQ  one-cycle pulse to the owning requester; at most one bit high.
- `rsp_quotient`  out  DWIDTH  shared result bus, valid while any `rsp_valid` bit is high.
- `rsp_remainder`  out  DWIDTH  shared result bus.
- `div_in_valid`  out  1  to divider `input_data_valid`.
- `div_in_ready`  in  1  from divider `input_ready_for_data`.
- `div_dividend`, `div_divisor`  out  DWIDTH  each, to divider.
- `div_out_valid`  in  1  from divider `output_data_valid`.
- `div_quotient`, `div_remainder`  in  DWIDTH  each, from divider.
- `outstanding`  out  clog2(TAG_DEPTH+1)  number of tags in flight.
- `err_orphan`  out  1  sticky; a divider result arrived with no tag pending.

## Operation

**Grant**
- Combinational priority search over `req_valid`, starting at index `last_grant+1` modulo `NUM_REQ`.
- `can_issue = div_in_ready && !tag_full`.
- `req_ready[g] = 1` only for the granted index g, and only when `can_issue`.
- Acceptance is `req_valid[g] && req_ready[g]`.

**Issue (zero latency)**
- On acceptance, in the same cycle:
  - `div_in_valid = 1`;
  - `div_dividend` / `div_divisor` = the slice of requester g;
  - tag g is pushed into the tag FIFO;
  - `last_grant <= g`.
- Without acceptance: `div_in_valid = 0`, `div_*` data = 0, and `last_grant` holds.
- The pointer advances only on acceptance. A requester that drops `req_valid` before being accepted loses no priority.

**Return**
- When `div_out_valid` is high, the tag FIFO pops the head tag t.
- Next cycle: `rsp_valid = 1 << t`, and `rsp_quotient` / `rsp_remainder` are registered copies of the divider outputs.
- The block does not inspect data; divide-by-zero results pass through unchanged.

**Boundary conditions**
- Tag FIFO full blocks any issue, even if a pop happens in the same cycle. The freed slot is usable the cycle after.
- Simultaneous push and pop when not full: both happen and `outstanding` is unchanged.
- `div_out_valid` with the FIFO empty:
  - `err_orphan` sets and stays set until reset;
  - no `rsp_valid` is generated;
  - `outstanding` stays 0.
- Requesters must hold `req_dividend`/`req_divisor` stable while `req_valid` is high and not yet accepted.

**Reset (`rst` == 0 at a clock edge)**
- `last_grant = NUM_REQ-1`, so requester 0 has first priority.
- Tag FIFO is flushed and `outstanding = 0`.
- `rsp_valid = 0`, `rsp_quotient = 0`, `rsp_remainder = 0`, `err_orphan = 0`.
- `req_ready` and `div_in_valid` are forced to 0 while `rst` is low.
- Reset mid-operation discards all pending tags. The top level resets the divider in the same cycle; divider results that arrive after reset release are flagged as orphans.

## Timing

- Request to `div_in_valid`: 0 cycles (combinational path from `req_valid`/`div_in_ready` to `div_in_valid`/`req_ready`).
- `div_out_valid` to `rsp_valid`: exactly 1 cycle.
- Throughput: one issue per cycle when the divider is ready and tags are available.
- `outstanding` is registered and reflects the pushes and pops of the previous edge.
- No combinational path from `div_out_valid` to any output.

## Structure

- Shared package `udiv_arb_pkg`:
  - `TAG_W = clog2(NUM_REQ)` (minimum 1);
  - `CNT_W = clog2(TAG_DEPTH+1)`;
  - a clog2 function;
  - default parameter constants.
- One sub-module, `tag_fifo`:
  - synchronous FIFO, width `TAG_W`, depth `TAG_DEPTH`;
  - pointers one bit wider than the address, so wrap-around is exact;
  - outputs `full`, `empty`, `count`;
  - same clock and reset polarity as this block.
- The arbiter top holds the round-robin pointer, the grant logic and the response register.

## Test plan

- **Reset:** hold `rst` = 0 for 3 cycles with all `req_valid` = 1 → `req_ready` = 0, `div_in_valid` = 0, `rsp_valid` = 0, `outstanding` = 0, `err_orphan` = 0.
- **Fairness:** `NUM_REQ` = 4, all requesters valid, `div_in_ready` = 1, divider model with 3-cycle in-order latency → grant order 0,1,2,3,0,…; each `rsp_valid` arrives 4 cycles after its issue, carrying the matching quotient (e.g. 1000/10 → quotient 100, remainder 0 to requester 0).
- **Skip idle:** only requesters 1 and 3 valid, starting from reset → grant order 1,3,1,3; requesters 0 and 2 never see `req_ready`.
- **Tag full:** `TAG_DEPTH` = 8, divider accepts but withholds results → exactly 8 issues, then `req_ready` = 0. The first `div_out_valid` yields `outstanding` = 7 on the next edge, and issue resumes the cycle after.
- **Orphan:** `div_out_valid` pulsed with the FIFO empty → `err_orphan` = 1 from the next cycle, no `rsp_valid`, flag held until reset.
- **Reset mid-flight:** 3 ops in flight, pulse `rst` low for 1 cycle → `outstanding` = 0, pointer restarts at requester 0, and a divider result arriving afterwards sets `err_orphan`.

Source files
------------

// File: rtl/udiv_arb_pkg.sv
// Shared constants and width helpers for the divider round-robin arbiter.
package udiv_arb_pkg;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_DWIDTH    = 32;
    localparam int unsigned DEF_TAG_DEPTH = 8;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A tag must be at least one bit wide even for a single-bit index space.
    function automatic int unsigned tag_w(input int unsigned num_req);
        return (clog2(num_req) < 1) ? 1 : clog2(num_req);
    endfunction

    localparam int unsigned DEF_TAG_W = tag_w(DEF_NUM_REQ);
    localparam int unsigned DEF_CNT_W = clog2(DEF_TAG_DEPTH + 1);

endpackage

// File: rtl/tag_fifo.sv
// Synchronous tag FIFO holding the requester index of each operation inside the divider.
module tag_fifo
    import udiv_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              din,
    output logic [WIDTH-1:0]              dout,
    output logic                          full,
    output logic                          empty,
    output logic [clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/udiv_rr_arbiter.sv
// Round-robin arbiter sharing one in-order unsigned divider among NUM_REQ requesters,
// routing each result back to its originator via a tag FIFO.
module udiv_rr_arbiter
    import udiv_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned DWIDTH    = DEF_DWIDTH,
    parameter int unsigned TAG_DEPTH = DEF_TAG_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DWIDTH-1:0]       req_dividend,
    input  logic [NUM_REQ*DWIDTH-1:0]       req_divisor,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DWIDTH-1:0]               rsp_quotient,
    output logic [DWIDTH-1:0]               rsp_remainder,
    output logic                            div_in_valid,
    input  logic                            div_in_ready,
    output logic [DWIDTH-1:0]               div_dividend,
    output logic [DWIDTH-1:0]               div_divisor,
    input  logic                            div_out_valid,
    input  logic [DWIDTH-1:0]               div_quotient,
    input  logic [DWIDTH-1:0]               div_remainder,
    output logic [clog2(TAG_DEPTH+1)-1:0]   outstanding,
    output logic                            err_orphan
);

    localparam int unsigned TAG_W = tag_w(NUM_REQ);
    localparam int unsigned CNT_W = clog2(TAG_DEPTH + 1);

    logic [TAG_W-1:0]   last_grant_q, last_grant_d;
    logic [TAG_W-1:0]   grant_idx;
    logic [TAG_W-1:0]   cand;
    int unsigned        cand_sum;
    logic               grant_found;
    logic               can_issue;
    logic               accept;
    logic               fifo_full;
    logic               fifo_empty;
    logic [TAG_W-1:0]   fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               pop;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0]  rsp_quot_q;
    logic [DWIDTH-1:0]  rsp_rem_q;
    logic               err_q, err_d;

    // Search starts one past the last accepted index, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        cand        = '0;
        cand_sum    = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand_sum = 32'(last_grant_q) + off;
            if (cand_sum >= NUM_REQ) begin
                cand_sum = cand_sum - NUM_REQ;
            end
            cand = TAG_W'(cand_sum);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // A full FIFO blocks issue even when a pop frees a slot on the same edge.
    assign can_issue    = rst && div_in_ready && !fifo_full;
    assign accept       = can_issue && grant_found;
    assign div_in_valid = accept;
    assign last_grant_d = accept ? grant_idx : last_grant_q;

    always_comb begin
        req_ready    = '0;
        div_dividend = '0;
        div_divisor  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (accept && (grant_idx == TAG_W'(i))) begin
                req_ready[i] = 1'b1;
                div_dividend = req_dividend[i*DWIDTH +: DWIDTH];
                div_divisor  = req_divisor[i*DWIDTH +: DWIDTH];
            end
        end
    end

    assign pop   = div_out_valid && !fifo_empty;
    assign err_d = err_q || (div_out_valid && fifo_empty);

    always_comb begin
        rsp_valid_d = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = pop && (fifo_head == TAG_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= TAG_W'(NUM_REQ - 1);
            rsp_valid_q  <= '0;
            rsp_quot_q   <= '0;
            rsp_rem_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            err_q        <= err_d;
            if (div_out_valid) begin
                rsp_quot_q <= div_quotient;
                rsp_rem_q  <= div_remainder;
            end
        end
    end

    tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (grant_idx),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rsp_valid     = rsp_valid_q;
    assign rsp_quotient  = rsp_quot_q;
    assign rsp_remainder = rsp_rem_q;
    assign outstanding   = fifo_count;
    assign err_orphan    = err_q;

endmodule

// File: tb/tb_udiv_rr_arbiter.sv
// Directed bench for udiv_rr_arbiter: vector table for grant/issue, sequences for
// fairness with a 3-cycle divider model, idle skipping, tag-full, orphan and reset.
module tb_udiv_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_dividend;
    logic [127:0] req_divisor;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_quotient;
    logic [31:0]  rsp_remainder;
    logic         div_in_valid;
    logic         div_in_ready;
    logic [31:0]  div_dividend;
    logic [31:0]  div_divisor;
    logic         div_out_valid;
    logic [31:0]  div_quotient;
    logic [31:0]  div_remainder;
    logic [3:0]   outstanding;
    logic         err_orphan;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    int unsigned  cyc = 0;

    // Divider stand-in: model_en selects a 3-stage in-order pipeline, otherwise manual drive.
    logic         model_en = 1'b0;
    logic         man_v = 1'b0;
    logic [31:0]  man_q = '0;
    logic [31:0]  man_r = '0;
    logic         st_v [3];
    logic [31:0]  st_q [3];
    logic [31:0]  st_r [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!model_en) begin
            for (int i = 0; i < 3; i++) st_v[i] <= 1'b0;
        end else begin
            st_v[0] <= div_in_valid && div_in_ready;
            st_q[0] <= (div_divisor == 0) ? 32'hFFFF_FFFF : div_dividend / div_divisor;
            st_r[0] <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
            for (int i = 1; i < 3; i++) begin
                st_v[i] <= st_v[i-1];
                st_q[i] <= st_q[i-1];
                st_r[i] <= st_r[i-1];
            end
        end
    end

    assign div_out_valid = model_en ? st_v[2] : man_v;
    assign div_quotient  = model_en ? st_q[2] : man_q;
    assign div_remainder = model_en ? st_r[2] : man_r;

    udiv_rr_arbiter #(
        .NUM_REQ   (4),
        .DWIDTH    (32),
        .TAG_DEPTH (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .div_in_valid  (div_in_valid),
        .div_in_ready  (div_in_ready),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_out_valid (div_out_valid),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .outstanding   (outstanding),
        .err_orphan    (err_orphan)
    );

    typedef struct {
        logic [3:0]  valid;
        logic        rdy;
        logic [3:0]  exp_ready;
        logic        exp_div_v;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [3:0]  exp_out;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] exp_q [4];
    logic [31:0] exp_r [4];
    int unsigned q_req [$];
    int unsigned q_cyc [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        model_en  = 1'b0;
        man_v     = 1'b0;
        next_cycle();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned n_issued;
        logic [3:0]  exp_rv;

        req_dividend = {32'd7, 32'd12345, 32'd77, 32'd1000};
        req_divisor  = {32'd0, 32'd100,   32'd5,  32'd10};
        exp_q = '{32'd100, 32'd15, 32'd123, 32'hFFFF_FFFF};
        exp_r = '{32'd0,   32'd2,  32'd45,  32'd7};

        vecs[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 32'd1000,  32'd10,  4'd0};
        vecs[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 32'd77,    32'd5,   4'd1};
        vecs[2] = '{4'b0101, 1'b1, 4'b0100, 1'b1, 32'd12345, 32'd100, 4'd2};
        vecs[3] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 32'd0,     32'd0,   4'd3};
        vecs[4] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 32'd1000,  32'd10,  4'd3};
        vecs[5] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'd0,     32'd0,   4'd4};
        vecs[6] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 32'd7,     32'd0,   4'd4};
        vecs[7] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 32'd77,    32'd5,   4'd5};

        // Reset held for 3 cycles with every requester asking.
        rst          = 1'b0;
        req_valid    = 4'b1111;
        div_in_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_req_ready", req_ready, 4'b0000);
            chk("rst_div_in_valid", div_in_valid, 1'b0);
            chk("rst_rsp_valid", rsp_valid, 4'b0000);
            chk("rst_outstanding", outstanding, 4'd0);
            chk("rst_err_orphan", err_orphan, 1'b0);
        end
        next_cycle();
        rst = 1'b1;

        // Table: grant search, issue data, pointer hold and outstanding count.
        for (int k = 0; k < 8; k++) begin
            req_valid    = vecs[k].valid;
            div_in_ready = vecs[k].rdy;
            @(negedge clk);
            chk("vec_req_ready", req_ready, vecs[k].exp_ready);
            chk("vec_div_in_valid", div_in_valid, vecs[k].exp_div_v);
            chk("vec_div_dividend", div_dividend, vecs[k].exp_a);
            chk("vec_div_divisor", div_divisor, vecs[k].exp_b);
            chk("vec_outstanding", outstanding, vecs[k].exp_out);
            next_cycle();
        end
        req_valid = '0;

        // Fairness with 3-cycle divider: results return 4 cycles after issue.
        do_reset();
        model_en     = 1'b1;
        div_in_ready = 1'b1;
        req_valid    = 4'b1111;
        n_issued     = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (div_in_valid === 1'b1) begin
                chk("fair_grant", req_ready, 4'b0001 << (n_issued % 4));
                q_req.push_back(n_issued % 4);
                q_cyc.push_back(cyc);
                n_issued++;
            end
            exp_rv = '0;
            if (q_cyc.size() > 0 && q_cyc[0] + 4 == cyc) exp_rv = 4'b0001 << q_req[0];
            chk("fair_rsp_valid", rsp_valid, exp_rv);
            if (exp_rv != 0) begin
                chk("fair_rsp_quotient", rsp_quotient, exp_q[q_req[0]]);
                chk("fair_rsp_remainder", rsp_remainder, exp_r[q_req[0]]);
                void'(q_req.pop_front());
                void'(q_cyc.pop_front());
            end
            next_cycle();
            if (n_issued >= 12) req_valid = '0;
        end
        chk("fair_issued", n_issued, 12);
        chk("fair_drained", q_req.size(), 0);
        model_en = 1'b0;

        // Only requesters 1 and 3 active: 0 and 2 must never be offered ready.
        do_reset();
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("skip_grant", req_ready, (k % 2 == 0) ? 4'b0010 : 4'b1000);
            next_cycle();
        end
        req_valid = '0;

        // Tag full: 8 issues then block; a pop in the full cycle does not issue.
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("full_div_in_valid", div_in_valid, (k < 8) ? 1'b1 : 1'b0);
            if (k >= 8) chk("full_req_ready", req_ready, 4'b0000);
            next_cycle();
        end
        man_v = 1'b1;
        man_q = 32'h1234;
        man_r = 32'h56;
        @(negedge clk);
        chk("full_out_8", outstanding, 4'd8);
        chk("full_pop_blocks", req_ready, 4'b0000);
        next_cycle();
        man_v = 1'b0;
        @(negedge clk);
        chk("full_out_7", outstanding, 4'd7);
        chk("full_resume", req_ready, 4'b0001);
        chk("full_rsp_valid", rsp_valid, 4'b0001);
        chk("full_rsp_quotient", rsp_quotient, 32'h1234);
        chk("full_rsp_remainder", rsp_remainder, 32'h56);
        next_cycle();
        @(negedge clk);
        chk("full_again", outstanding, 4'd8);
        chk("full_again_blocked", div_in_valid, 1'b0);
        req_valid = '0;

        // Orphan result with an empty FIFO.
        do_reset();
        man_v = 1'b1;
        man_q = 32'd5;
        @(negedge clk);
        chk("orph_before", err_orphan, 1'b0);
        next_cycle();
        man_v = 1'b0;
        @(negedge clk);
        chk("orph_set", err_orphan, 1'b1);
        chk("orph_no_rsp", rsp_valid, 4'b0000);
        chk("orph_outstanding", outstanding, 4'd0);
        for (int k = 0; k < 3; k++) next_cycle();
        @(negedge clk);
        chk("orph_sticky", err_orphan, 1'b1);
        do_reset();
        @(negedge clk);
        chk("orph_cleared", err_orphan, 1'b0);

        // Reset with 3 ops in flight.
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) next_cycle();
        req_valid = '0;
        @(negedge clk);
        chk("mid_outstanding_3", outstanding, 4'd3);
        next_cycle();
        rst       = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("mid_rst_ready", req_ready, 4'b0000);
        chk("mid_rst_div_in_valid", div_in_valid, 1'b0);
        next_cycle();
        rst       = 1'b1;
        req_valid = '0;
        man_v     = 1'b1;
        @(negedge clk);
        chk("mid_outstanding_0", outstanding, 4'd0);
        chk("mid_err_before", err_orphan, 1'b0);
        next_cycle();
        man_v     = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("mid_err_orphan", err_orphan, 1'b1);
        chk("mid_no_rsp", rsp_valid, 4'b0000);
        chk("mid_ptr_restart", req_ready, 4'b0001);
        next_cycle();
        req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
